// File: rtl/pe_array_downstream_dist.sv
`default_nettype none
// ============================================================================
// pe_array_downstream_dist : routes stack-bus words into per-PE show-ahead FIFOs
// Revision: 1.0
// ============================================================================
module pe_array_downstream_dist #(
  parameter int NUM_PE     = 64,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int PE_ID_W    = 8
) (
  input  logic                       clk,
  input  logic                       reset_poweron,
  input  logic                       sys__pearray__valid,
  output logic                       sys__pearray__ready,
  input  logic                       sys__pearray__bcast,
  input  logic [PE_ID_W-1:0]         sys__pearray__peId,
  input  logic [DATA_W-1:0]          sys__pearray__data,
  output logic [NUM_PE-1:0]          pearray__pe__valid,
  input  logic [NUM_PE-1:0]          pe__pearray__ready,
  output logic [NUM_PE*DATA_W-1:0]   pearray__pe__data,
  output logic [15:0]                pearray__sys__dropCount,
  output logic                       pearray__sys__idle
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [OCC_W-1:0] C_FULL = OCC_W'(FIFO_DEPTH);

  logic [31:0]       w_peid_ext;
  logic              w_in_range;
  logic              w_accept;
  logic              w_drop;
  logic [NUM_PE-1:0] w_hit;
  logic [NUM_PE-1:0] w_full;
  logic [NUM_PE-1:0] w_empty;
  logic [NUM_PE-1:0] w_push;
  logic [NUM_PE-1:0] w_pop;
  logic [15:0]       r_drop_cnt;

  assign w_peid_ext = 32'(sys__pearray__peId);
  assign w_in_range = (w_peid_ext < 32'(NUM_PE));

  // Out-of-range ids hit no channel, so they see ready=1 and are dropped.
  assign sys__pearray__ready = sys__pearray__bcast ? ~|w_full : ~|(w_full & w_hit);
  assign w_accept = sys__pearray__valid & sys__pearray__ready;
  assign w_drop   = w_accept & ~sys__pearray__bcast & ~w_in_range;

  assign pearray__sys__idle      = &w_empty;
  assign pearray__sys__dropCount = r_drop_cnt;

  always_ff @(posedge clk or posedge reset_poweron) begin
    if (reset_poweron) begin
      r_drop_cnt <= 16'd0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  for (genvar i = 0; i < NUM_PE; i++) begin : g_ch
    logic [OCC_W-1:0]  r_occ;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];

    assign w_hit[i]   = (w_peid_ext == 32'(i));
    assign w_full[i]  = (r_occ == C_FULL);
    assign w_empty[i] = (r_occ == '0);
    // Push is gated by registered full only, so a full channel never takes a word while popping.
    assign w_push[i]  = w_accept & (sys__pearray__bcast | w_hit[i]);
    assign w_pop[i]   = ~w_empty[i] & pe__pearray__ready[i];

    always_ff @(posedge clk or posedge reset_poweron) begin
      if (reset_poweron) begin
        r_occ    <= '0;
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_push[i]) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_pop[i])  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        case ({w_push[i], w_pop[i]})
          2'b10:   r_occ <= r_occ + OCC_W'(1);
          2'b01:   r_occ <= r_occ - OCC_W'(1);
          default: r_occ <= r_occ;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (w_push[i]) r_mem[r_wr_ptr] <= sys__pearray__data;
    end

    assign pearray__pe__valid[i]                 = ~w_empty[i];
    assign pearray__pe__data[i*DATA_W +: DATA_W] = r_mem[r_rd_ptr];
  end

endmodule
`default_nettype wire

// File: tb/tb_pe_array_downstream_dist.sv
`default_nettype none
// ============================================================================
// tb_pe_array_downstream_dist : directed bench for the 4-channel configuration
// Revision: 1.0
// ============================================================================
module tb_pe_array_downstream_dist;

  logic         clk;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic         s_bcast;
  logic [7:0]   s_peid;
  logic [31:0]  s_data;
  logic [3:0]   pe_valid;
  logic [3:0]   pe_ready;
  logic [127:0] pe_data;
  logic [15:0]  drop_cnt;
  logic         idle;

  int n_cmp;
  int n_err;

  pe_array_downstream_dist #(
    .NUM_PE(4), .DATA_W(32), .FIFO_DEPTH(4), .PE_ID_W(8)
  ) dut (
    .clk                     (clk),
    .reset_poweron           (rst),
    .sys__pearray__valid     (s_valid),
    .sys__pearray__ready     (s_ready),
    .sys__pearray__bcast     (s_bcast),
    .sys__pearray__peId      (s_peid),
    .sys__pearray__data      (s_data),
    .pearray__pe__valid      (pe_valid),
    .pe__pearray__ready      (pe_ready),
    .pearray__pe__data       (pe_data),
    .pearray__sys__dropCount (drop_cnt),
    .pearray__sys__idle      (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; s_valid = 1'b0; s_bcast = 1'b0; s_peid = 8'd0; s_data = 32'd0; pe_ready = 4'b0000;
    tick(); tick();
    n_cmp++; if (pe_valid !== 4'b0000) begin n_err++; $display("FAIL rst_valid: got %b want %b", pe_valid, 4'b0000); end
    n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL rst_idle: got %b want 1", idle); end
    n_cmp++; if (drop_cnt !== 16'd0) begin n_err++; $display("FAIL rst_drop: got %h want 0000", drop_cnt); end
    n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", s_ready); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_unicast();
    s_valid = 1'b1; s_peid = 8'd2; s_data = 32'hA5A50001; pe_ready = 4'b0000;
    #1;
    n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL uni_ready: got %b want 1", s_ready); end
    tick();
    s_valid = 1'b0;
    n_cmp++; if (pe_valid !== 4'b0100) begin n_err++; $display("FAIL uni_valid: got %b want %b", pe_valid, 4'b0100); end
    n_cmp++; if (pe_data[64 +: 32] !== 32'hA5A50001) begin n_err++; $display("FAIL uni_data: got %h want a5a50001", pe_data[64 +: 32]); end
    n_cmp++; if (idle !== 1'b0) begin n_err++; $display("FAIL uni_idle: got %b want 0", idle); end
    pe_ready = 4'b0100;
    tick();
    pe_ready = 4'b0000;
    n_cmp++; if (pe_valid !== 4'b0000) begin n_err++; $display("FAIL uni_drain: got %b want 0000", pe_valid); end
    n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL uni_idle_after: got %b want 1", idle); end
  endtask

  task automatic test_backpressure();
    pe_ready = 4'b0000; s_peid = 8'd1; s_bcast = 1'b0;
    for (int k = 0; k < 4; k++) begin
      s_valid = 1'b1; s_data = 32'h1000 + k;
      #1;
      n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL bp_fill_ready%0d: got %b want 1", k, s_ready); end
      tick();
    end
    s_data = 32'h1004;
    #1;
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL bp_fifth_ready: got %b want 0", s_ready); end
    tick();
    pe_ready = 4'b0010;
    #1;
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL bp_ready_indep: got %b want 0", s_ready); end
    n_cmp++; if (pe_data[32 +: 32] !== 32'h1000) begin n_err++; $display("FAIL bp_head0: got %h want 00001000", pe_data[32 +: 32]); end
    tick();
    n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL bp_ready_back: got %b want 1", s_ready); end
    n_cmp++; if (pe_data[32 +: 32] !== 32'h1001) begin n_err++; $display("FAIL bp_head1: got %h want 00001001", pe_data[32 +: 32]); end
    tick();
    s_valid = 1'b0;
    for (int k = 2; k <= 4; k++) begin
      n_cmp++; if (pe_data[32 +: 32] !== 32'h1000 + k) begin n_err++; $display("FAIL bp_order%0d: got %h want %h", k, pe_data[32 +: 32], 32'h1000 + k); end
      tick();
    end
    pe_ready = 4'b0000;
    n_cmp++; if (pe_valid !== 4'b0000) begin n_err++; $display("FAIL bp_empty: got %b want 0000", pe_valid); end
  endtask

  task automatic test_broadcast();
    pe_ready = 4'b0000; s_bcast = 1'b0; s_peid = 8'd3;
    for (int k = 0; k < 4; k++) begin
      s_valid = 1'b1; s_data = 32'h3000 + k;
      tick();
    end
    s_bcast = 1'b1; s_data = 32'h0000BEEF;
    #1;
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL bc_blocked: got %b want 0", s_ready); end
    tick();
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL bc_still_blocked: got %b want 0", s_ready); end
    pe_ready = 4'b1000;
    tick();
    pe_ready = 4'b0000;
    #1;
    n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL bc_ready: got %b want 1", s_ready); end
    tick();
    s_valid = 1'b0; s_bcast = 1'b0;
    n_cmp++; if (pe_valid !== 4'b1111) begin n_err++; $display("FAIL bc_valid: got %b want 1111", pe_valid); end
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (pe_data[c*32 +: 32] !== 32'h0000BEEF) begin n_err++; $display("FAIL bc_data_ch%0d: got %h want 0000beef", c, pe_data[c*32 +: 32]); end
    end
    pe_ready = 4'b1000;
    for (int k = 1; k <= 3; k++) begin
      n_cmp++; if (pe_data[96 +: 32] !== 32'h3000 + k) begin n_err++; $display("FAIL bc_ch3_order%0d: got %h want %h", k, pe_data[96 +: 32], 32'h3000 + k); end
      tick();
    end
    n_cmp++; if (pe_data[96 +: 32] !== 32'h0000BEEF) begin n_err++; $display("FAIL bc_ch3_last: got %h want 0000beef", pe_data[96 +: 32]); end
    pe_ready = 4'b1111;
    tick();
    pe_ready = 4'b0000;
    n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL bc_idle: got %b want 1", idle); end
  endtask

  task automatic test_drop();
    s_bcast = 1'b0; s_peid = 8'd7; s_data = 32'hDEAD0000;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1;
      #1;
      n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL drop_ready%0d: got %b want 1", k, s_ready); end
      tick();
    end
    s_valid = 1'b0;
    n_cmp++; if (pe_valid !== 4'b0000) begin n_err++; $display("FAIL drop_valid: got %b want 0000", pe_valid); end
    n_cmp++; if (drop_cnt !== 16'd3) begin n_err++; $display("FAIL drop_cnt3: got %h want 0003", drop_cnt); end
    s_valid = 1'b1;
    for (int k = 0; k < 65531; k++) tick();
    s_valid = 1'b0;
    n_cmp++; if (drop_cnt !== 16'hFFFE) begin n_err++; $display("FAIL drop_cnt_fffe: got %h want fffe", drop_cnt); end
    s_valid = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    s_valid = 1'b0;
    n_cmp++; if (drop_cnt !== 16'hFFFF) begin n_err++; $display("FAIL drop_sat: got %h want ffff", drop_cnt); end
    s_peid = 8'd0;
  endtask

  task automatic test_push_pop();
    pe_ready = 4'b0000; s_bcast = 1'b0; s_peid = 8'd0;
    for (int k = 0; k < 4; k++) begin
      s_valid = 1'b1; s_data = 32'h4000 + k;
      tick();
    end
    s_data = 32'h4004; pe_ready = 4'b0001;
    #1;
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL pp_full_ready: got %b want 0", s_ready); end
    tick();
    s_valid = 1'b0;
    n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL pp_not_full: got %b want 1", s_ready); end
    for (int k = 1; k <= 3; k++) begin
      n_cmp++; if (pe_data[0 +: 32] !== 32'h4000 + k) begin n_err++; $display("FAIL pp_drain%0d: got %h want %h", k, pe_data[0 +: 32], 32'h4000 + k); end
      tick();
    end
    n_cmp++; if (pe_valid[0] !== 1'b0) begin n_err++; $display("FAIL pp_occ3: got %b want 0", pe_valid[0]); end
    pe_ready = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      s_valid = 1'b1; s_data = 32'h5000 + k;
      tick();
    end
    pe_ready = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      s_valid = 1'b1; s_data = 32'h5002 + k;
      #1;
      n_cmp++; if (pe_data[0 +: 32] !== 32'h5000 + k) begin n_err++; $display("FAIL pp_wrap%0d: got %h want %h", k, pe_data[0 +: 32], 32'h5000 + k); end
      n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL pp_wrap_ready%0d: got %b want 1", k, s_ready); end
      tick();
    end
    s_valid = 1'b0;
    n_cmp++; if (pe_data[0 +: 32] !== 32'h500A) begin n_err++; $display("FAIL pp_tail0: got %h want 0000500a", pe_data[0 +: 32]); end
    tick();
    n_cmp++; if (pe_data[0 +: 32] !== 32'h500B) begin n_err++; $display("FAIL pp_tail1: got %h want 0000500b", pe_data[0 +: 32]); end
    tick();
    pe_ready = 4'b0000;
    n_cmp++; if (pe_valid !== 4'b0000) begin n_err++; $display("FAIL pp_empty: got %b want 0000", pe_valid); end
  endtask

  task automatic test_reset_mid();
    pe_ready = 4'b0000; s_bcast = 1'b0; s_peid = 8'd0;
    for (int k = 0; k < 3; k++) begin
      s_valid = 1'b1; s_data = 32'h7000 + k;
      tick();
    end
    s_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (pe_valid !== 4'b0000) begin n_err++; $display("FAIL rmid_valid: got %b want 0000", pe_valid); end
    n_cmp++; if (idle !== 1'b1) begin n_err++; $display("FAIL rmid_idle: got %b want 1", idle); end
    tick();
    rst = 1'b0;
    s_valid = 1'b1; s_data = 32'h6000;
    #1;
    n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL rmid_ready: got %b want 1", s_ready); end
    tick();
    s_valid = 1'b0;
    n_cmp++; if (pe_valid !== 4'b0001) begin n_err++; $display("FAIL rmid_first_valid: got %b want 0001", pe_valid); end
    n_cmp++; if (pe_data[0 +: 32] !== 32'h6000) begin n_err++; $display("FAIL rmid_first_data: got %h want 00006000", pe_data[0 +: 32]); end
    pe_ready = 4'b0001;
    tick();
    pe_ready = 4'b0000;
    n_cmp++; if (pe_valid !== 4'b0000) begin n_err++; $display("FAIL rmid_only: got %b want 0000", pe_valid); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_unicast();
    test_backpressure();
    test_broadcast();
    test_drop();
    test_push_pop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
